// File: rtl/hamming_scrub_pkg.sv
// ---------------------------------------------------------------------------
// hamming_scrub_pkg
// Shared types and helpers for the Hamming scrub sequencer.
//   scrub_state_e : sequencer FSM states
//   SETTLE_W      : width of the settle-wait counter (SETTLE is 1..7)
//   timer_width() : width of the scrub-interval timer for a given period
//   is_busy()     : states in which scrub_busy is reported
// ---------------------------------------------------------------------------
package hamming_scrub_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SNAP,
        ST_WAIT,
        ST_CHECK,
        ST_CORR,
        ST_VWAIT,
        ST_VCHECK,
        ST_FAULT
    } scrub_state_e;

    localparam int SETTLE_W = 3;

    function automatic int timer_width(input int period);
        return $clog2(period);
    endfunction

    // The busy window runs from the snapshot through the verification wait.
    // VCHECK is the verdict cycle; the release of busy after a correction is
    // therefore one cycle ahead of the irq_corr / corr_count update.
    function automatic logic is_busy(input scrub_state_e s);
        return s inside {ST_SNAP, ST_WAIT, ST_CHECK, ST_CORR, ST_VWAIT};
    endfunction

endpackage

// File: rtl/hamming_scrub_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for the shared increment port. Produces the one-hot
// grant for the next cycle; the caller registers it. Owns the RR pointer,
// which names the last granted index and only moves on a grant.
//   clk, rst  : clock, async active-high reset (pointer -> N_REQ-1)
//   req       : level requests
//   mask      : requesters excluded this cycle (those currently granted)
//   en        : arbitration enable; no grant and no pointer move when low
//   gnt_next  : one-hot grant, zero when nothing eligible
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             en,
    output logic [N_REQ-1:0] gnt_next
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] hi_sel;
    logic [N_REQ-1:0] lo_sel;

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        cand     = en ? (req & ~mask) : '0;
        hi_sel   = '0;
        lo_sel   = '0;
        ptr_next = ptr;
        // Scanning downwards and overwriting leaves the lowest eligible index
        // above the pointer in hi_sel, and the lowest at or below it in lo_sel.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                if (i > int'(ptr)) begin
                    hi_sel    = '0;
                    hi_sel[i] = 1'b1;
                end else begin
                    lo_sel    = '0;
                    lo_sel[i] = 1'b1;
                end
            end
        end
        gnt_next = (|hi_sel) ? hi_sel : lo_sel;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_next[i]) begin
                ptr_next = PTR_W'(i);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PTR_W'(N_REQ - 1);
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/hamming_scrub_sequencer.sv
// ---------------------------------------------------------------------------
// hamming_scrub_sequencer
// Controller for the nibble-Hamming protected counter. Shares the counter's
// increment port among N_REQ requesters (round-robin) and periodically runs a
// scrub: snapshot parity, wait, check, correct, wait, verify. Increments are
// frozen while a scrub is pending or running. An uncorrectable syndrome, or a
// correction that does not verify, locks the block in FAULT until rst.
//   clk, rst    : clock, async active-high reset
//   req         : level increment requests, held until granted
//   gnt         : one-hot grant pulse, one increment per pulse
//   scrub_req   : pulse, request a scrub as soon as possible
//   dp_inc      : increment strobe (== |gnt)
//   dp_snap     : capture-parity strobe
//   dp_correct  : apply-correction strobe
//   dp_syn_nz   : syndrome nonzero (valid SETTLE cycles after a strobe)
//   dp_uncorr   : syndrome not correctable
//   scrub_busy  : scrub sequence in progress
//   irq_corr    : one-cycle pulse on a verified correction
//   corr_count  : saturating count of verified corrections
//   fault       : sticky unrecoverable error
// All outputs are registered.
// ---------------------------------------------------------------------------
module hamming_scrub_sequencer
    import hamming_scrub_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int SCRUB_PERIOD = 1024,
    parameter int SETTLE       = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    input  logic             scrub_req,
    output logic             dp_inc,
    output logic             dp_snap,
    output logic             dp_correct,
    input  logic             dp_syn_nz,
    input  logic             dp_uncorr,
    output logic             scrub_busy,
    output logic             irq_corr,
    output logic [CNT_W-1:0] corr_count,
    output logic             fault
);

    localparam int                    TIMER_W     = timer_width(SCRUB_PERIOD);
    localparam logic [TIMER_W-1:0]    TIMER_LAST  = TIMER_W'(SCRUB_PERIOD - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    scrub_state_e         state;
    scrub_state_e         state_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;
    logic                 pending;
    logic                 pending_next;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [SETTLE_W-1:0]  settle_next;
    logic [CNT_W-1:0]     count_next;
    logic                 irq_next;
    logic                 arb_en;
    logic                 scrub_seen;
    logic [N_REQ-1:0]     gnt_next;

    // The registered grant masks its own requester, so a lone requester is
    // served every other cycle and never twice in a row.
    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mask     (gnt),
        .en       (arb_en),
        .gnt_next (gnt_next)
    );

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        settle_next  = settle_cnt;
        count_next   = corr_count;
        irq_next     = 1'b0;
        arb_en       = 1'b0;
        scrub_seen   = scrub_req && (state != ST_FAULT);
        // A request during a scrub is remembered and replayed on return to RUN.
        pending_next = pending || scrub_seen;

        unique case (state)
            ST_RUN: begin
                if (pending) begin
                    state_next   = ST_SNAP;
                    timer_next   = '0;
                    pending_next = scrub_seen;
                end else begin
                    timer_next   = (timer == TIMER_LAST) ? '0 : timer + TIMER_W'(1);
                    pending_next = (timer == TIMER_LAST) || scrub_seen;
                    // The cycle a scrub becomes pending already carries no grant.
                    arb_en       = !pending_next;
                end
            end
            ST_SNAP: begin
                settle_next = SETTLE_LOAD;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (settle_cnt == '0) begin
                    state_next = ST_CHECK;
                end else begin
                    settle_next = settle_cnt - SETTLE_W'(1);
                end
            end
            ST_CHECK: begin
                if (dp_uncorr) begin
                    state_next = ST_FAULT;
                end else if (!dp_syn_nz) begin
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_CORR;
                end
            end
            ST_CORR: begin
                settle_next = SETTLE_LOAD;
                state_next  = ST_VWAIT;
            end
            ST_VWAIT: begin
                if (settle_cnt == '0) begin
                    state_next = ST_VCHECK;
                end else begin
                    settle_next = settle_cnt - SETTLE_W'(1);
                end
            end
            ST_VCHECK: begin
                if (!dp_syn_nz) begin
                    state_next = ST_RUN;
                    irq_next   = 1'b1;
                    if (corr_count != {CNT_W{1'b1}}) begin
                        count_next = corr_count + CNT_W'(1);
                    end
                end else begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so each strobe lines
    // up with the cycle its state occupies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            timer      <= '0;
            pending    <= 1'b0;
            settle_cnt <= '0;
            gnt        <= '0;
            dp_inc     <= 1'b0;
            dp_snap    <= 1'b0;
            dp_correct <= 1'b0;
            scrub_busy <= 1'b0;
            irq_corr   <= 1'b0;
            corr_count <= '0;
            fault      <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            pending    <= pending_next;
            settle_cnt <= settle_next;
            gnt        <= gnt_next;
            dp_inc     <= |gnt_next;
            dp_snap    <= (state_next == ST_SNAP);
            dp_correct <= (state_next == ST_CORR);
            scrub_busy <= is_busy(state_next);
            irq_corr   <= irq_next;
            corr_count <= count_next;
            fault      <= (state_next == ST_FAULT);
        end
    end

endmodule
